codec_sample_sched: RTL and testbench

Per-frame sample scheduler between the codec interface and the output side of the digital core. It starts on each rising edge of the codec interface's `valid` level and captures that frame's left and right input samples. It then runs both channels through a 4-tap FIR on one shared 16x16 signed multiplier: left taps first, then right. Both filtered results are presented together, with a `done` pulse, long before the next frame.

---
 rtl/codec_sample_sched.sv | 184 ++++++++++++++++++
 tb/tb_codec_sample_sched.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/codec_sample_sched.sv
// Per-frame sample scheduler: captures a stereo sample pair on each valid rise and
// runs both channels through a shared-multiplier 4-tap FIR, left channel then right.
module codec_sample_sched #(
   parameter int unsigned TAPS = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid,
   input  logic [15:0] lft_in,
   input  logic [15:0] rht_in,
   input  logic        cfg_wr,
   input  logic [1:0]  cfg_addr,
   input  logic [15:0] cfg_data,
   output logic        cfg_rdy,
   output logic [15:0] lft_out,
   output logic [15:0] rht_out,
   output logic        busy,
   output logic        done,
   output logic        overrun
);

   localparam int unsigned DW  = 16;
   localparam int unsigned PW  = 32;
   localparam int unsigned AW  = 34;
   localparam int unsigned KW  = $clog2(TAPS);
   localparam int unsigned FRAC = 14;
   localparam logic [KW-1:0]        K_LAST = KW'(TAPS - 1);
   localparam logic signed [AW-1:0] SAT_HI = 34'sd32767;
   localparam logic signed [AW-1:0] SAT_LO = -34'sd32768;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LMAC = 2'd1,
      S_RMAC = 2'd2,
      S_WB   = 2'd3
   } state_e;

   state_e                state_q, state_d;
   logic [KW-1:0]         k_q, k_d;
   logic signed [AW-1:0]  acc_q, acc_d;
   logic [DW-1:0]         lres_q, lres_d, rres_q, rres_d;
   logic [DW-1:0]         lft_out_q, lft_out_d, rht_out_q, rht_out_d;
   logic                  done_q, done_d, busy_q, busy_d, cfg_rdy_q, cfg_rdy_d;
   logic                  overrun_q, overrun_d, valid_q;
   logic signed [DW-1:0]  xl_q [TAPS];
   logic signed [DW-1:0]  xl_d [TAPS];
   logic signed [DW-1:0]  xr_q [TAPS];
   logic signed [DW-1:0]  xr_d [TAPS];
   logic signed [DW-1:0]  coef_q [TAPS];
   logic signed [DW-1:0]  coef_d [TAPS];

   logic                  start_c;
   logic signed [DW-1:0]  mul_a_c, mul_b_c;
   logic signed [PW-1:0]  prod_c;
   logic signed [AW-1:0]  acc_nxt_c;
   logic [DW-1:0]         sat_c;

   // Q2.14 accumulator back to a 16-bit sample with clipping
   function automatic logic [DW-1:0] sat16(input logic signed [AW-1:0] a);
      logic signed [AW-1:0] s;
      s = a >>> FRAC;
      if (s > SAT_HI)      sat16 = 16'h7FFF;
      else if (s < SAT_LO) sat16 = 16'h8000;
      else                 sat16 = s[DW-1:0];
   endfunction

   assign start_c   = valid & ~valid_q;

   // single shared multiplier; the operand mux picks the channel by state
   assign mul_a_c   = coef_q[k_q];
   assign mul_b_c   = (state_q == S_RMAC) ? xr_q[k_q] : xl_q[k_q];
   assign prod_c    = mul_a_c * mul_b_c;
   assign acc_nxt_c = acc_q + $signed({{(AW-PW){prod_c[PW-1]}}, prod_c});
   assign sat_c     = sat16(acc_nxt_c);

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      acc_d     = acc_q;
      lres_d    = lres_q;
      rres_d    = rres_q;
      lft_out_d = lft_out_q;
      rht_out_d = rht_out_q;
      done_d    = 1'b0;
      overrun_d = overrun_q;
      xl_d      = xl_q;
      xr_d      = xr_q;
      coef_d    = coef_q;

      if (cfg_wr && cfg_rdy_q) coef_d[cfg_addr] = cfg_data;
      if (start_c && (state_q != S_IDLE)) overrun_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (start_c) begin
               for (int i = TAPS - 1; i > 0; i--) begin
                  xl_d[i] = xl_q[i-1];
                  xr_d[i] = xr_q[i-1];
               end
               xl_d[0] = lft_in;
               xr_d[0] = rht_in;
               acc_d   = '0;
               k_d     = '0;
               state_d = S_LMAC;
            end
         end
         S_LMAC: begin
            acc_d = acc_nxt_c;
            k_d   = k_q + 1'b1;
            if (k_q == K_LAST) begin
               lres_d  = sat_c;
               acc_d   = '0;
               state_d = S_RMAC;
            end
         end
         S_RMAC: begin
            acc_d = acc_nxt_c;
            k_d   = k_q + 1'b1;
            if (k_q == K_LAST) begin
               rres_d  = sat_c;
               acc_d   = '0;
               state_d = S_WB;
            end
         end
         S_WB: begin
            lft_out_d = lres_q;
            rht_out_d = rres_q;
            done_d    = 1'b1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      busy_d    = (state_d != S_IDLE);
      cfg_rdy_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         k_q       <= '0;
         acc_q     <= '0;
         lres_q    <= '0;
         rres_q    <= '0;
         lft_out_q <= '0;
         rht_out_q <= '0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         cfg_rdy_q <= 1'b1;
         overrun_q <= 1'b0;
         valid_q   <= 1'b0;
         for (int i = 0; i < TAPS; i++) begin
            xl_q[i]   <= '0;
            xr_q[i]   <= '0;
            coef_q[i] <= '0;
         end
         coef_q[0] <= 16'sh4000;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         acc_q     <= acc_d;
         lres_q    <= lres_d;
         rres_q    <= rres_d;
         lft_out_q <= lft_out_d;
         rht_out_q <= rht_out_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
         cfg_rdy_q <= cfg_rdy_d;
         overrun_q <= overrun_d;
         valid_q   <= valid;
         xl_q      <= xl_d;
         xr_q      <= xr_d;
         coef_q    <= coef_d;
      end
   end

   assign cfg_rdy = cfg_rdy_q;
   assign lft_out = lft_out_q;
   assign rht_out = rht_out_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_codec_sample_sched.sv
// Bench for codec_sample_sched: directed frames plus random coefficient/sample frames,
// checked against an arithmetic FIR model.
module tb_codec_sample_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid;
   logic [15:0] lft_in, rht_in;
   logic        cfg_wr;
   logic [1:0]  cfg_addr;
   logic [15:0] cfg_data;
   logic        cfg_rdy;
   logic [15:0] lft_out, rht_out;
   logic        busy, done, overrun;

   int errors = 0;
   int checks = 0;

   logic signed [15:0] m_c  [4];
   logic signed [15:0] m_xl [4];
   logic signed [15:0] m_xr [4];
   logic [15:0]        m_lout, m_rout;
   bit                 m_ovr;

   codec_sample_sched #(.TAPS(4)) dut (
      .clk(clk), .rst_n(rst_n), .valid(valid), .lft_in(lft_in), .rht_in(rht_in),
      .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_rdy(cfg_rdy),
      .lft_out(lft_out), .rht_out(rht_out), .busy(busy), .done(done), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_c[0] = 16'sh4000;
      for (int i = 1; i < 4; i++) m_c[i] = '0;
      for (int i = 0; i < 4; i++) begin
         m_xl[i] = '0;
         m_xr[i] = '0;
      end
      m_lout = '0;
      m_rout = '0;
      m_ovr  = 1'b0;
   endtask

   task automatic model_shift(input logic [15:0] l, input logic [15:0] r);
      for (int i = 3; i > 0; i--) begin
         m_xl[i] = m_xl[i-1];
         m_xr[i] = m_xr[i-1];
      end
      m_xl[0] = l;
      m_xr[0] = r;
   endtask

   function automatic logic [15:0] ref_fir(input bit right);
      longint acc;
      acc = 0;
      for (int k = 0; k < 4; k++)
         acc += longint'(m_c[k]) * longint'(right ? m_xr[k] : m_xl[k]);
      acc = acc >>> 14;
      if (acc > 32767)  return 16'h7FFF;
      if (acc < -32768) return 16'h8000;
      return 16'(acc);
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      valid = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
      @(negedge clk);
      chk("cfg_rdy_idle", 32'(cfg_rdy), 32'd1);
      cfg_wr = 1'b1; cfg_addr = a; cfg_data = d;
      @(posedge clk); #1;
      cfg_wr = 1'b0;
      m_c[a] = d;
   endtask

   // Waits for done after n0 edges past E0 have already elapsed.
   task automatic wait_done(input int n0, input logic [15:0] el, input logic [15:0] er);
      int  n;
      bit  seen;
      n = n0;
      seen = 1'b0;
      while (!seen && n < 20) begin
         @(posedge clk); #1;
         n++;
         chk("busy_window", 32'(busy), 32'(n < 9));
         if (done === 1'b1) seen = 1'b1;
         else begin
            chk("hold_l", 32'(lft_out), 32'(m_lout));
            chk("hold_r", 32'(rht_out), 32'(m_rout));
         end
      end
      chk("done_latency", 32'(n), 32'd9);
      chk("lft_out", 32'(lft_out), 32'(el));
      chk("rht_out", 32'(rht_out), 32'(er));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      m_lout = el;
      m_rout = er;
      @(posedge clk); #1;
      chk("done_pulse_end", 32'(done), 32'd0);
      chk("cfg_rdy_after", 32'(cfg_rdy), 32'd1);
   endtask

   task automatic frame(input logic [15:0] l, input logic [15:0] r, input bit wr_busy);
      logic [15:0] el, er;
      int n0;
      @(negedge clk);
      lft_in = l; rht_in = r; valid = 1'b1;
      model_shift(l, r);
      el = ref_fir(1'b0);
      er = ref_fir(1'b1);
      @(posedge clk); #1;
      valid = 1'b0;
      lft_in = ~l; rht_in = ~r;
      chk("busy_e0", 32'(busy), 32'd1);
      chk("cfg_rdy_busy", 32'(cfg_rdy), 32'd0);
      n0 = 0;
      if (wr_busy) begin
         cfg_wr = 1'b1; cfg_addr = 2'd0; cfg_data = 16'h0000;
         @(posedge clk); #1;
         cfg_wr = 1'b0;
         n0 = 1;
      end
      wait_done(n0, el, er);
   endtask

   initial begin
      logic [15:0] el, er;
      rst_n = 1'b0; valid = 1'b0; lft_in = '0; rht_in = '0;
      cfg_wr = 1'b0; cfg_addr = '0; cfg_data = '0;
      model_reset();
      #12;
      chk("rst_lft", 32'(lft_out), 32'd0);
      chk("rst_rht", 32'(rht_out), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ovr", 32'(overrun), 32'd0);
      chk("rst_cfg_rdy", 32'(cfg_rdy), 32'd1);
      @(negedge clk); rst_n = 1'b1;

      // passthrough after reset
      frame(16'd1000, 16'hF63C, 1'b0);

      // moving average of a step
      do_reset();
      for (int k = 0; k < 4; k++) cfg_write(2'(k), 16'h1000);
      for (int i = 0; i < 4; i++) frame(16'd4000, 16'd0, 1'b0);

      // saturation both directions
      cfg_write(2'd0, 16'h7FFF);
      frame(16'd20000, 16'hB1E0, 1'b0);

      // write while busy is dropped
      do_reset();
      frame(16'd1234, 16'hEF1F, 1'b1);
      frame(16'd777, 16'h8001, 1'b0);

      // second start while busy: ignored, overrun set
      @(negedge clk);
      lft_in = 16'd3000; rht_in = 16'hF000; valid = 1'b1;
      model_shift(16'd3000, 16'hF000);
      el = ref_fir(1'b0);
      er = ref_fir(1'b1);
      @(posedge clk); #1;
      valid = 1'b0; lft_in = 16'd5555; rht_in = 16'd6666;
      repeat (3) @(posedge clk);
      #1 valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      m_ovr = 1'b1;
      wait_done(4, el, er);
      frame(16'd100, 16'd200, 1'b0);

      // reset during the right-channel MACs
      @(negedge clk);
      lft_in = 16'd9000; rht_in = 16'd9001; valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      model_reset();
      #1;
      chk("midrst_lft", 32'(lft_out), 32'd0);
      chk("midrst_rht", 32'(rht_out), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_cfg_rdy", 32'(cfg_rdy), 32'd1);
      chk("midrst_ovr", 32'(overrun), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         chk("no_spurious_done", 32'(done), 32'd0);
      end
      frame(16'(32'($urandom)), 16'(32'($urandom)), 1'b0);

      // random coefficients and samples
      for (int i = 0; i < 16; i++) begin
         if ($urandom_range(0, 1) == 1)
            cfg_write(2'($urandom_range(0, 3)), 16'(32'($urandom)));
         repeat ($urandom_range(0, 5)) @(negedge clk);
         frame(16'(32'($urandom)), 16'(32'($urandom)), 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
